bus_monitor: RTL and testbench



---
 rtl/bus_monitor.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_bus_monitor.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_monitor.sv
// -----------------------------------------------------------------------------
// bus_monitor
//
// Passive transaction monitor for one copperv ready/valid request/response bus
// pair. Request handshakes push {address, cycle stamp} into a small FIFO.
// Response handshakes pop the oldest entry. One cycle later the completed
// transaction is reported with its address, data and latency. The block also
// keeps a saturating transaction count and sticky protocol-error flags. It
// never drives the bus.
//
// Optional feature macro: BUS_MONITOR_LATENCY_EN
//   defined   : free-running stamp counter, per-entry stamps, resp_latency and
//               max_latency are implemented.
//   undefined : the stamp logic is omitted, entries hold only the address, and
//               resp_latency / max_latency are tied to 0.
//
// Parameters
//   ADDR_WIDTH  request address width
//   DATA_WIDTH  response data width
//   DEPTH       outstanding-request FIFO depth (power of 2, >= 2)
//   TIMEOUT     cycles an outstanding request may wait before err[4] sets
//   CNT_WIDTH   width of stamp, latency and count registers
//
// Ports
//   clk           clock
//   rst           asynchronous active-low reset
//   clear         synchronous clear of err, txn_count, max_latency
//   addr_valid    request channel valid
//   addr_ready    request channel ready
//   addr          request address
//   data_valid    response channel valid
//   data_ready    response channel ready
//   data          response data
//   resp_valid    one-cycle pulse, matched transaction completed
//   resp_addr     address of completed transaction
//   resp_data     data of completed transaction
//   resp_latency  cycles from request handshake to response handshake
//   max_latency   largest resp_latency since reset/clear
//   outstanding   current FIFO occupancy
//   txn_count     completed transactions (saturating)
//   err           sticky flags: [0] request stall, [1] response stall,
//                 [2] underflow, [3] overflow, [4] timeout
// -----------------------------------------------------------------------------
module bus_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       addr_valid,
  input  logic                       addr_ready,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic                       data_valid,
  input  logic                       data_ready,
  input  logic [DATA_WIDTH-1:0]      data,
  output logic                       resp_valid,
  output logic [ADDR_WIDTH-1:0]      resp_addr,
  output logic [DATA_WIDTH-1:0]      resp_data,
  output logic [CNT_WIDTH-1:0]       resp_latency,
  output logic [CNT_WIDTH-1:0]       max_latency,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic [CNT_WIDTH-1:0]       txn_count,
  output logic [4:0]                 err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int WD_W  = $clog2(TIMEOUT+1);

  localparam logic [OCC_W-1:0]     FULL_CNT  = OCC_W'(DEPTH);
  localparam logic [WD_W-1:0]      WD_LIMIT  = WD_W'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_count;
  logic [WD_W-1:0]       r_wd;

  logic                  r_addr_stalled;
  logic [ADDR_WIDTH-1:0] r_addr_held;
  logic                  r_data_stalled;
  logic [DATA_WIDTH-1:0] r_data_held;

  logic                  r_resp_valid;
  logic [ADDR_WIDTH-1:0] r_resp_addr;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic [CNT_WIDTH-1:0]  r_txn_count;
  logic [4:0]            r_err;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic w_push_req;
  logic w_pop_req;
  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;
  logic w_underflow;
  logic w_overflow;
  logic w_addr_stall_err;
  logic w_data_stall_err;
  logic w_timeout_hit;
  logic [4:0] w_err_events;

  assign w_push_req  = addr_valid && addr_ready;
  assign w_pop_req   = data_valid && data_ready;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);

  // Emptiness is judged at cycle start: a same-cycle push cannot satisfy a
  // pop, since a zero-cycle response is not a legal transaction.
  assign w_pop_ok    = w_pop_req && !w_empty;
  assign w_underflow = w_pop_req && w_empty;

  // When full, a simultaneous pop frees the slot this push needs.
  assign w_push_ok   = w_push_req && (!w_full || w_pop_ok);
  assign w_overflow  = w_push_req && w_full && !w_pop_ok;

  // A stalled beat must be held with identical payload on the next cycle.
  assign w_addr_stall_err = r_addr_stalled && (!addr_valid || (addr != r_addr_held));
  assign w_data_stall_err = r_data_stalled && (!data_valid || (data != r_data_held));

  // The watchdog reaches the limit at this edge (or is already parked there).
  // Using >= lets the flag re-assert after a clear while a request is still
  // overdue.
  assign w_timeout_hit = !w_empty && !w_pop_ok && (r_wd >= (WD_LIMIT - WD_W'(1)));

  assign w_err_events = {w_timeout_hit, w_overflow, w_underflow,
                         w_data_stall_err, w_addr_stall_err};

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem_addr[r_wr_ptr] <= addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: counts consecutive cycles with something outstanding and no pop
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd <= '0;
    end else if (w_empty || w_pop_ok) begin
      r_wd <= '0;
    end else if (r_wd != WD_LIMIT) begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stall trackers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_stalled <= 1'b0;
      r_addr_held    <= '0;
      r_data_stalled <= 1'b0;
      r_data_held    <= '0;
    end else begin
      r_addr_stalled <= addr_valid && !addr_ready;
      r_addr_held    <= addr;
      r_data_stalled <= data_valid && !data_ready;
      r_data_held    <= data;
    end
  end

  // ---------------------------------------------------------------------------
  // Response, count and error registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_resp_addr <= r_mem_addr[r_rd_ptr];
        r_resp_data <= data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txn_count <= '0;
      r_err       <= '0;
    end else if (clear) begin
      r_txn_count <= '0;
      r_err       <= '0;
    end else begin
      if (w_pop_ok && (r_txn_count != CNT_MAX)) begin
        r_txn_count <= r_txn_count + CNT_WIDTH'(1);
      end
      r_err <= r_err | w_err_events;
    end
  end

  // ---------------------------------------------------------------------------
  // Latency measurement
  // ---------------------------------------------------------------------------
`ifdef BUS_MONITOR_LATENCY_EN
  logic [CNT_WIDTH-1:0] r_stamp;
  logic [CNT_WIDTH-1:0] r_mem_stamp [DEPTH];
  logic [CNT_WIDTH-1:0] r_resp_latency;
  logic [CNT_WIDTH-1:0] r_max_latency;
  logic [CNT_WIDTH-1:0] w_latency;

  // Modular subtraction makes the measurement correct across stamp wrap.
  assign w_latency = r_stamp - r_mem_stamp[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stamp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_stamp[i] <= '0;
      end
    end else begin
      r_stamp <= r_stamp + CNT_WIDTH'(1);
      if (w_push_ok) begin
        r_mem_stamp[r_wr_ptr] <= r_stamp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_latency <= '0;
      r_max_latency  <= '0;
    end else begin
      if (w_pop_ok) begin
        r_resp_latency <= w_latency;
      end
      if (clear) begin
        r_max_latency <= '0;
      end else if (w_pop_ok && (w_latency > r_max_latency)) begin
        r_max_latency <= w_latency;
      end
    end
  end

  assign resp_latency = r_resp_latency;
  assign max_latency  = r_max_latency;
`else
  assign resp_latency = '0;
  assign max_latency  = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign resp_valid  = r_resp_valid;
  assign resp_addr   = r_resp_addr;
  assign resp_data   = r_resp_data;
  assign outstanding = r_count;
  assign txn_count   = r_txn_count;
  assign err         = r_err;

endmodule

// File: tb/tb_bus_monitor.sv
// -----------------------------------------------------------------------------
// tb_bus_monitor
//
// Self-checking bench for bus_monitor (DEPTH=4, TIMEOUT=8). A directed vector
// table covers the single-transaction, back-to-back fill and overflow/underflow
// scenarios with hand-computed expectations; hand-written sequences cover
// stall violations, clear, timeout and reset mid-operation; a randomized phase
// is checked against a queue-based transaction model.
// -----------------------------------------------------------------------------
module tb_bus_monitor;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int CW    = 16;
  localparam int OW    = $clog2(DEPTH+1);

`ifdef BUS_MONITOR_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          clr;
  logic          av, ar, dv, dr;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  logic          resp_valid;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] resp_data;
  logic [CW-1:0] resp_latency;
  logic [CW-1:0] max_latency;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] txn_count;
  logic [4:0]    err;

  bus_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clr),
    .addr_valid(av), .addr_ready(ar), .addr(addr),
    .data_valid(dv), .data_ready(dr), .data(data),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_data(resp_data),
    .resp_latency(resp_latency), .max_latency(max_latency),
    .outstanding(outstanding), .txn_count(txn_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue of outstanding {address, issue cycle}
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [AW-1:0] a;
    int            issued;
  } ent_t;

  ent_t          m_q[$];
  logic [4:0]    m_err;
  int            m_txn;
  int            m_max;
  int            m_cyc;
  int            m_idle_since;
  bit            m_prev_a_stall;
  logic [AW-1:0] m_prev_addr;
  bit            m_prev_d_stall;
  logic [DW-1:0] m_prev_data;
  bit            e_rv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            e_lat;

  task automatic model_reset();
    m_q.delete();
    m_err = '0; m_txn = 0; m_max = 0; m_cyc = 0; m_idle_since = 0;
    m_prev_a_stall = 0; m_prev_addr = '0; m_prev_d_stall = 0; m_prev_data = '0;
    e_rv = 0;
  endtask

  // Evaluate one clock cycle from the inputs currently driven.
  task automatic model_eval();
    bit   push, pop;
    int   occ;
    ent_t ent;
    logic [4:0] ev;
    push = av && ar;
    pop  = dv && dr;
    occ  = m_q.size();
    ev   = '0;
    e_rv = 0;
    if (m_prev_a_stall && (!av || addr != m_prev_addr)) ev[0] = 1'b1;
    if (m_prev_d_stall && (!dv || data != m_prev_data)) ev[1] = 1'b1;
    if (pop) begin
      if (occ == 0) ev[2] = 1'b1;
      else begin
        ent    = m_q.pop_front();
        e_rv   = 1;
        e_addr = ent.a;
        e_data = data;
        e_lat  = (m_cyc - ent.issued) & 32'hFFFF;
        if (m_txn < 65535) m_txn++;
        if (e_lat > m_max) m_max = e_lat;
      end
    end
    if (push) begin
      if (occ == DEPTH && !(pop && occ > 0)) ev[3] = 1'b1;
      else m_q.push_back('{a: addr, issued: m_cyc});
    end
    if (occ == 0 || (pop && occ > 0)) m_idle_since = m_cyc;
    else if (m_cyc - m_idle_since >= TMO) ev[4] = 1'b1;
    m_err = m_err | ev;
    if (clr) begin
      m_err = '0; m_txn = 0; m_max = 0;
    end
    m_prev_a_stall = av && !ar;
    m_prev_addr    = addr;
    m_prev_d_stall = dv && !dr;
    m_prev_data    = data;
    m_cyc++;
  endtask

  task automatic compare_model();
    chk("resp_valid", resp_valid, e_rv);
    if (e_rv) begin
      chk("resp_addr", resp_addr, e_addr);
      chk("resp_data", resp_data, e_data);
      chk("resp_latency", resp_latency, LAT_EN ? e_lat : 0);
    end
    chk("outstanding", outstanding, m_q.size());
    chk("txn_count", txn_count, m_txn);
    chk("err", err, m_err);
    chk("max_latency", max_latency, LAT_EN ? m_max : 0);
    if (resp_valid)
      $display("txn addr=%08h data=%08h lat=%0d count=%0d", resp_addr, resp_data, resp_latency, txn_count);
  endtask

  // One clock: model the cycle, clock the DUT, sample 1 time unit later.
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_idle();
    av = 0; ar = 0; addr = '0; dv = 0; dr = 0; data = '0; clr = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rv"},  resp_valid, 0);
    chk({tag, "_ra"},  resp_addr, 0);
    chk({tag, "_rd"},  resp_data, 0);
    chk({tag, "_lat"}, resp_latency, 0);
    chk({tag, "_max"}, max_latency, 0);
    chk({tag, "_out"}, outstanding, 0);
    chk({tag, "_txn"}, txn_count, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          av, ar;
    logic [AW-1:0] a;
    logic          dv, dr;
    logic [DW-1:0] d;
    logic          x_rv;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_data;
    int            x_lat;
    int            x_out;
    int            x_txn;
    logic [4:0]    x_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit av_i, bit ar_i, logic [AW-1:0] a_i, bit dv_i, bit dr_i,
                              logic [DW-1:0] d_i, bit rv_x, logic [AW-1:0] a_x,
                              logic [DW-1:0] d_x, int lat_x, int out_x, int txn_x,
                              logic [4:0] err_x);
    vec_t v;
    v.av = av_i; v.ar = ar_i; v.a = a_i; v.dv = dv_i; v.dr = dr_i; v.d = d_i;
    v.x_rv = rv_x; v.x_addr = a_x; v.x_data = d_x; v.x_lat = lat_x;
    v.x_out = out_x; v.x_txn = txn_x; v.x_err = err_x;
    return v;
  endfunction

  initial begin
    // single transaction
    vecs.push_back(mk(1,1,32'h100, 0,0,0,            0,0,0,0, 1, 0, 5'h00));
    vecs.push_back(mk(0,0,0,       0,0,0,            0,0,0,0, 1, 0, 5'h00));
    vecs.push_back(mk(0,0,0,       0,0,0,            0,0,0,0, 1, 0, 5'h00));
    vecs.push_back(mk(0,0,0,       1,1,32'hDEADBEEF, 1,32'h100,32'hDEADBEEF,3, 0, 1, 5'h00));
    // back-to-back fill, push+pop while full, drain
    vecs.push_back(mk(1,1,32'h0,   0,0,0,            0,0,0,0, 1, 1, 5'h00));
    vecs.push_back(mk(1,1,32'h4,   0,0,0,            0,0,0,0, 2, 1, 5'h00));
    vecs.push_back(mk(1,1,32'h8,   0,0,0,            0,0,0,0, 3, 1, 5'h00));
    vecs.push_back(mk(1,1,32'hC,   0,0,0,            0,0,0,0, 4, 1, 5'h00));
    vecs.push_back(mk(1,1,32'h40,  1,1,32'hD0000000, 1,32'h0, 32'hD0000000,4, 4, 2, 5'h00));
    vecs.push_back(mk(0,0,0,       1,1,32'hD0000001, 1,32'h4, 32'hD0000001,4, 3, 3, 5'h00));
    vecs.push_back(mk(0,0,0,       1,1,32'hD0000002, 1,32'h8, 32'hD0000002,4, 2, 4, 5'h00));
    vecs.push_back(mk(0,0,0,       1,1,32'hD0000003, 1,32'hC, 32'hD0000003,4, 1, 5, 5'h00));
    vecs.push_back(mk(0,0,0,       1,1,32'hD0000004, 1,32'h40,32'hD0000004,4, 0, 6, 5'h00));
    // overflow then underflow
    vecs.push_back(mk(1,1,32'h0,   0,0,0,            0,0,0,0, 1, 6, 5'h00));
    vecs.push_back(mk(1,1,32'h4,   0,0,0,            0,0,0,0, 2, 6, 5'h00));
    vecs.push_back(mk(1,1,32'h8,   0,0,0,            0,0,0,0, 3, 6, 5'h00));
    vecs.push_back(mk(1,1,32'hC,   0,0,0,            0,0,0,0, 4, 6, 5'h00));
    vecs.push_back(mk(1,1,32'h10,  0,0,0,            0,0,0,0, 4, 6, 5'h08));
    vecs.push_back(mk(0,0,0,       1,1,32'hE0,       1,32'h0, 32'hE0,5, 3, 7, 5'h08));
    vecs.push_back(mk(0,0,0,       1,1,32'hE1,       1,32'h4, 32'hE1,5, 2, 8, 5'h08));
    vecs.push_back(mk(0,0,0,       1,1,32'hE2,       1,32'h8, 32'hE2,5, 1, 9, 5'h08));
    vecs.push_back(mk(0,0,0,       1,1,32'hE3,       1,32'hC, 32'hE3,5, 0,10, 5'h08));
    vecs.push_back(mk(0,0,0,       1,1,32'hE4,       0,0,0,0, 0,10, 5'h0C));
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    repeat (3) begin
      set_idle();
      step();
    end

    // directed table
    for (int i = 0; i < vecs.size(); i++) begin
      set_idle();
      av = vecs[i].av; ar = vecs[i].ar; addr = vecs[i].a;
      dv = vecs[i].dv; dr = vecs[i].dr; data = vecs[i].d;
      step();
      chk($sformatf("tbl%0d_rv", i), resp_valid, vecs[i].x_rv);
      if (vecs[i].x_rv) begin
        chk($sformatf("tbl%0d_addr", i), resp_addr, vecs[i].x_addr);
        chk($sformatf("tbl%0d_data", i), resp_data, vecs[i].x_data);
        chk($sformatf("tbl%0d_lat", i), resp_latency, LAT_EN ? vecs[i].x_lat : 0);
      end
      chk($sformatf("tbl%0d_out", i), outstanding, vecs[i].x_out);
      chk($sformatf("tbl%0d_txn", i), txn_count, vecs[i].x_txn);
      chk($sformatf("tbl%0d_err", i), err, vecs[i].x_err);
    end

    // clear returns flags and counters to zero
    set_idle(); clr = 1; step();
    chk("clear_err", err, 0);
    chk("clear_txn", txn_count, 0);
    chk("clear_max", max_latency, 0);

    // request-side stall violation: address changes while stalled
    set_idle(); av = 1; ar = 0; addr = 32'h20; step();
    chk("stall_a_hold", err, 0);
    set_idle(); av = 1; ar = 0; addr = 32'h24; step();
    chk("stall_a_err", err[0], 1);
    set_idle(); av = 1; ar = 1; addr = 32'h24; step();
    chk("stall_a_push", outstanding, 1);
    // response-side stall violation: valid dropped while stalled
    set_idle(); dv = 1; dr = 0; data = 32'h55; step();
    chk("stall_d_hold", err[1], 0);
    set_idle(); step();
    chk("stall_d_err", err, 5'h03);
    set_idle(); dv = 1; dr = 1; data = 32'h66; step();
    chk("stall_pop_rv", resp_valid, 1);
    chk("stall_pop_addr", resp_addr, 32'h24);
    set_idle(); clr = 1; step();
    chk("stall_clear", err, 0);

    // timeout: one push, no response
    set_idle(); av = 1; ar = 1; addr = 32'h300; step();
    repeat (7) begin
      set_idle(); step();
    end
    chk("timeout_early", err[4], 0);
    set_idle(); step();
    chk("timeout_set", err[4], 1);
    set_idle(); dv = 1; dr = 1; data = 32'hCAFE; step();
    chk("timeout_late_rv", resp_valid, 1);
    chk("timeout_late_lat", resp_latency, LAT_EN ? 9 : 0);
    set_idle(); step();
    chk("timeout_sticky", err[4], 1);
    set_idle(); clr = 1; step();

    // reset with two entries outstanding
    set_idle(); av = 1; ar = 1; addr = 32'h500; step();
    set_idle(); av = 1; ar = 1; addr = 32'h504; step();
    chk("rst_mid_pre", outstanding, 2);
    set_idle();
    rst = 1'b0;
    #1;
    model_reset();
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    chk("rst_mid_hold_out", outstanding, 0);
    chk("rst_mid_hold_rv", resp_valid, 0);
    rst = 1'b1;
    set_idle(); step();
    chk("rst_after_rv", resp_valid, 0);
    set_idle(); dv = 1; dr = 1; data = 32'h77; step();
    chk("rst_after_underflow", err[2], 1);
    chk("rst_after_no_rv", resp_valid, 0);

    // randomized traffic against the model
    set_idle(); clr = 1; step();
    for (int n = 0; n < 1500; n++) begin
      clr = 0;
      if (av && !ar && ($urandom_range(7) != 0)) av = 1;
      else begin
        av   = ($urandom_range(1) == 1);
        addr = $urandom & 32'h0000_FFFC;
      end
      ar = ($urandom_range(9) < 6);
      if (dv && !dr && ($urandom_range(7) != 0)) dv = 1;
      else begin
        dv   = ($urandom_range(1) == 1);
        data = $urandom;
      end
      dr  = ($urandom_range(9) < 6);
      clr = ($urandom_range(39) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
